io_port_bank: RTL and testbench

//  Parametrised GPIO bank for the Mini-CPU. Generalises the fixed TRISA/TRISB pair to NUM_PORTS ports of

---
 rtl/io_port_pkg.sv | 14 +
 rtl/io_port_slice.sv | 66 ++++++
 rtl/io_port_bank.sv | 70 +++++++
 tb/tb_io_port_bank.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/io_port_pkg.sv
// Shared definitions for the GPIO port bank: write-op encodings and bank limits.
package io_port_pkg;

  typedef enum logic [2:0] {
    OP_TRIS = 3'b000,
    OP_LAT  = 3'b001,
    OP_BSF  = 3'b010,
    OP_BCF  = 3'b011,
    OP_IOCM = 3'b100
  } wr_op_e;

  localparam int MAX_PORTS = 8;

endpackage

// File: rtl/io_port_slice.sv
// One GPIO port: direction, output latch, IOC mask/reference, input synchroniser
// and sticky interrupt-on-change flag.
module io_port_slice
  import io_port_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [2:0]       wr_op,
  input  logic [WIDTH-1:0] w,
  input  logic             rd_en,
  input  logic             ioc_clr,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] tris,
  output logic [WIDTH-1:0] lat,
  output logic [WIDTH-1:0] sync_in,
  output logic             ioc_flag
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] ioc_mask;
  logic [WIDTH-1:0] ioc_ref;
  logic             mismatch;

  // NOTE: this is a handful of flops, not a RAM, so every stage is reset; real memories would be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_in  = sync_q[SYNC_STAGES-1];
  assign mismatch = |((sync_in ^ ioc_ref) & ioc_mask & tris);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tris     <= '1;
      lat      <= '0;
      ioc_mask <= '0;
      ioc_ref  <= '0;
      ioc_flag <= 1'b0;
    end else begin
      if (wr_en) begin
        case (wr_op)
          OP_TRIS: tris     <= w;
          OP_LAT:  lat      <= w;
          OP_BSF:  lat      <= lat | w;
          OP_BCF:  lat      <= lat & ~w;
          OP_IOCM: ioc_mask <= w;
          default: ;
        endcase
      end
      // Re-arming the reference on read or mask write avoids a stale mismatch.
      if (rd_en || (wr_en && wr_op == OP_IOCM)) ioc_ref <= sync_in;
      ioc_flag <= mismatch | (ioc_flag & ~ioc_clr);
    end
  end

endmodule

// File: rtl/io_port_bank.sv
// Parametrised GPIO bank: port select decode, registered read mux and irq OR over
// NUM_PORTS instances of io_port_slice.
module io_port_bank
  import io_port_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [2:0]                 wr_op,
  input  logic [2:0]                 wr_sel,
  input  logic [WIDTH-1:0]           W,
  input  logic                       rd_en,
  input  logic [2:0]                 rd_sel,
  output logic [WIDTH-1:0]           rd_data,
  input  logic [NUM_PORTS-1:0]       ioc_clr,
  input  logic [NUM_PORTS*WIDTH-1:0] pin_in,
  output logic [NUM_PORTS*WIDTH-1:0] pin_out,
  output logic [NUM_PORTS*WIDTH-1:0] pin_oe,
  output logic [NUM_PORTS-1:0]       ioc_flag,
  output logic                       irq
);

  logic [WIDTH-1:0] tris    [NUM_PORTS];
  logic [WIDTH-1:0] lat     [NUM_PORTS];
  logic [WIDTH-1:0] sync_in [NUM_PORTS];
  logic [WIDTH-1:0] rd_mux;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    io_port_slice #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_slice (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en && (wr_sel == 3'(p))),
      .wr_op   (wr_op),
      .w       (W),
      .rd_en   (rd_en && (rd_sel == 3'(p))),
      .ioc_clr (ioc_clr[p]),
      .pin_in  (pin_in[p*WIDTH +: WIDTH]),
      .tris    (tris[p]),
      .lat     (lat[p]),
      .sync_in (sync_in[p]),
      .ioc_flag(ioc_flag[p])
    );

    assign pin_out[p*WIDTH +: WIDTH] = lat[p];
    assign pin_oe[p*WIDTH +: WIDTH]  = ~tris[p];
  end

  // NOTE: default assigned first so no path through the select loop leaves rd_mux unassigned (no latch).
  always_comb begin
    rd_mux = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rd_sel == 3'(p)) rd_mux = (sync_in[p] & tris[p]) | (lat[p] & ~tris[p]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= rd_mux;
  end

  assign irq = |ioc_flag;

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank (2 ports x 8 bits, 2 sync stages); read
// results are scored through an expected-value queue.
module tb_io_port_bank;
  import io_port_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_op;
  logic [2:0]  wr_sel;
  logic [7:0]  W;
  logic        rd_en;
  logic [2:0]  rd_sel;
  logic [7:0]  rd_data;
  logic [1:0]  ioc_clr;
  logic [15:0] pin_in;
  logic [15:0] pin_out;
  logic [15:0] pin_oe;
  logic [1:0]  ioc_flag;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q [$];
  logic [7:0] got, exp;

  io_port_bank #(.NUM_PORTS(2), .WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_op(wr_op), .wr_sel(wr_sel), .W(W),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data), .ioc_clr(ioc_clr),
    .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .ioc_flag(ioc_flag), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] sel, input logic [2:0] op, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_op = op; W = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Pushes the expected value, then issues the read; caller pops and compares.
  task automatic do_read(input logic [2:0] sel, input logic [7:0] e);
    exp_q.push_back(e);
    rd_en = 1'b1; rd_sel = sel;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_op = '0; wr_sel = '0; W = '0;
    rd_en = 1'b0; rd_sel = '0; ioc_clr = '0; pin_in = '0;
    tick();
    rst = 1'b0;
    tick();
    do_write(3'd0, OP_TRIS, 8'h00);
    do_write(3'd0, OP_LAT, 8'hFF);
    do_read(3'd0, 8'hFF);
    got = rd_data; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL pre_reset_read: got %h expected %h", got, exp); end
    n_tests++;
    if (pin_out !== 16'h00FF) begin n_fail++; $display("FAIL pre_reset_pin_out: got %h expected 00ff", pin_out); end
    wr_en = 1'b1; wr_sel = 3'd0; wr_op = OP_LAT; W = 8'h12;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({pin_oe, pin_out, rd_data, irq} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_async: got oe=%h out=%h rd=%h irq=%b expected all 0", pin_oe, pin_out, rd_data, irq);
    end
    tick();
    rst = 1'b0; wr_en = 1'b0;
    tick();
    n_tests++;
    if (pin_out !== 16'h0000 || pin_oe !== 16'h0000) begin
      n_fail++; $display("FAIL reset_abort_write: got out=%h oe=%h expected 0000/0000", pin_out, pin_oe);
    end
  endtask

  task automatic test_dir_lat_read();
    do_write(3'd0, OP_TRIS, 8'h0F);
    do_write(3'd0, OP_LAT, 8'hA5);
    n_tests++;
    if (pin_oe[7:0] !== 8'hF0) begin n_fail++; $display("FAIL port0_oe: got %h expected f0", pin_oe[7:0]); end
    n_tests++;
    if (pin_out[7:0] !== 8'hA5) begin n_fail++; $display("FAIL port0_out: got %h expected a5", pin_out[7:0]); end
    pin_in[7:0] = 8'h3C;
    tick(); tick();
    do_read(3'd0, 8'hAC);
    got = rd_data; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL port0_mixed_read: got %h expected %h", got, exp); end
  endtask

  task automatic test_bit_ops();
    do_write(3'd0, OP_LAT, 8'h00);
    do_write(3'd0, OP_BSF, 8'h81);
    n_tests++;
    if (pin_out[7:0] !== 8'h81) begin n_fail++; $display("FAIL bsf: got %h expected 81", pin_out[7:0]); end
    do_write(3'd0, OP_BCF, 8'h01);
    n_tests++;
    if (pin_out[7:0] !== 8'h80) begin n_fail++; $display("FAIL bcf: got %h expected 80", pin_out[7:0]); end
    do_write(3'd7, OP_LAT, 8'hFF);
    do_write(3'd0, 3'b101, 8'hFF);
    do_write(3'd1, 3'b111, 8'h00);
    n_tests++;
    if (pin_out !== 16'h0080 || pin_oe !== 16'h00F0) begin
      n_fail++; $display("FAIL ignored_writes: got out=%h oe=%h expected 0080/00f0", pin_out, pin_oe);
    end
    do_read(3'd7, 8'h00);
    got = rd_data; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL read_bad_sel: got %h expected %h", got, exp); end
  endtask

  task automatic test_ioc();
    do_write(3'd1, OP_TRIS, 8'hFF);
    do_write(3'd1, OP_IOCM, 8'hF0);
    pin_in[8] = 1'b1;
    repeat (4) tick();
    n_tests++;
    if (ioc_flag[1] !== 1'b0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL ioc_masked_bit: got flag=%b irq=%b expected 0/0", ioc_flag[1], irq);
    end
    pin_in[12] = 1'b1;
    tick(); tick();
    n_tests++;
    if (ioc_flag[1] !== 1'b0) begin n_fail++; $display("FAIL ioc_early: got %b expected 0", ioc_flag[1]); end
    tick();
    n_tests++;
    if (ioc_flag !== 2'b10 || irq !== 1'b1) begin
      n_fail++; $display("FAIL ioc_set: got flag=%b irq=%b expected 10/1", ioc_flag, irq);
    end
    do_read(3'd1, 8'h11);
    got = rd_data; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL ioc_read: got %h expected %h", got, exp); end
    ioc_clr = 2'b10;
    tick();
    ioc_clr = 2'b00;
    n_tests++;
    if (ioc_flag[1] !== 1'b0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL ioc_clear: got flag=%b irq=%b expected 0/0", ioc_flag[1], irq);
    end
  endtask

  task automatic test_ioc_clr_race();
    pin_in[13] = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (ioc_flag[1] !== 1'b1) begin n_fail++; $display("FAIL race_setup: got %b expected 1", ioc_flag[1]); end
    ioc_clr = 2'b10;
    pin_in[14] = 1'b1;
    tick();
    ioc_clr = 2'b00;
    n_tests++;
    if (ioc_flag[1] !== 1'b1 || irq !== 1'b1) begin
      n_fail++; $display("FAIL set_beats_clear: got flag=%b irq=%b expected 1/1", ioc_flag[1], irq);
    end
    tick(); tick();
    do_read(3'd1, 8'h71);
    got = rd_data; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL race_read: got %h expected %h", got, exp); end
    ioc_clr = 2'b10;
    tick();
    ioc_clr = 2'b00;
    n_tests++;
    if (ioc_flag[1] !== 1'b0) begin n_fail++; $display("FAIL race_clear: got %b expected 0", ioc_flag[1]); end
    do_write(3'd1, OP_TRIS, 8'h00);
    pin_in[15] = 1'b1;
    repeat (4) tick();
    n_tests++;
    if (ioc_flag[1] !== 1'b0 || pin_oe[15:8] !== 8'hFF) begin
      n_fail++; $display("FAIL output_no_flag: got flag=%b oe=%h expected 0/ff", ioc_flag[1], pin_oe[15:8]);
    end
  endtask

  task automatic test_back_to_back();
    do_write(3'd0, OP_TRIS, 8'h00);
    do_write(3'd0, OP_LAT, 8'hAA);
    exp_q.push_back(8'hAA);
    wr_en = 1'b1; wr_sel = 3'd0; wr_op = OP_LAT; W = 8'h55;
    rd_en = 1'b1; rd_sel = 3'd0;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    got = rd_data; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL same_cycle_read: got %h expected %h", got, exp); end
    tick();
    n_tests++;
    if (rd_data !== 8'hAA) begin n_fail++; $display("FAIL rd_data_hold: got %h expected aa", rd_data); end
    do_read(3'd0, 8'h55);
    got = rd_data; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL next_read: got %h expected %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_dir_lat_read();
    test_bit_ops();
    test_ioc();
    test_ioc_clr_race();
    test_back_to_back();
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
